// File: rtl/fetch_pkg.sv
// Shared fetch-side types: the entry carried from the instruction cache to decode.
package fetch_pkg;

  localparam int IQ_DEPTH = 8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        excp;
  } fetch_entry_t;

endpackage

// File: rtl/inst_queue.sv
// Fetch-to-decode instruction queue, first-word fall-through: a push in cycle N is visible at the head in cycle N+1.
// Upstream throttles on almost_full; a push into a full queue without a pop is dropped and latches ovf.
module inst_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH    = IQ_DEPTH,
  parameter int AF_LEVEL = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [31:0]                in_pc,
  input  logic [31:0]                in_inst,
  input  logic                       in_excp,
  output logic                       almost_full,
  output logic                       full,
  output logic                       out_valid,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_inst,
  output logic                       out_excp,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  // almost_full when free entries (DEPTH - count) <= AF_LEVEL
  localparam logic [CW-1:0] AF_COUNT   = CW'(DEPTH - AF_LEVEL);

  fetch_entry_t mem [DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic          push;
  logic          pop;
  logic          drop;
  fetch_entry_t  head_entry;
  fetch_entry_t  in_entry;

  assign full        = (count == FULL_COUNT);
  assign almost_full = (count >= AF_COUNT);
  assign out_valid   = (count != '0);

  assign pop  = out_valid && out_ready && !flush;
  // A pop frees the head slot in the same edge, so a full queue still accepts.
  assign push = in_valid && !flush && (!full || pop);
  assign drop = in_valid && !flush && full && !pop;

  assign in_entry.pc   = in_pc;
  assign in_entry.inst = in_inst;
  assign in_entry.excp = in_excp;

  assign head_entry = mem[head];
  assign out_pc     = head_entry.pc;
  assign out_inst   = head_entry.inst;
  assign out_excp   = head_entry.excp;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= in_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Directed and random stimulus for inst_queue against a queue-based reference model.
module tb_inst_queue;
  import fetch_pkg::*;

  localparam int DEPTH = 8;
  localparam int AF    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        in_excp;
  logic        almost_full;
  logic        full;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_excp;
  logic        out_ready;
  logic [3:0]  count;
  logic        ovf;

  inst_queue #(.DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_excp(in_excp),
    .almost_full(almost_full), .full(full),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst), .out_excp(out_excp),
    .out_ready(out_ready), .count(count), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  fetch_entry_t mq[$];
  logic         m_ovf = 1'b0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model(string tag);
    int n;
    n = mq.size();
    chk({tag, ".count"}, 32'(count), 32'(n));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(n != 0));
    chk({tag, ".full"}, 32'(full), 32'(n == DEPTH));
    chk({tag, ".almost_full"}, 32'(almost_full), 32'((DEPTH - n) <= AF));
    chk({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
    if (n != 0) begin
      chk({tag, ".out_pc"}, out_pc, mq[0].pc);
      chk({tag, ".out_inst"}, out_inst, mq[0].inst);
      chk({tag, ".out_excp"}, 32'(out_excp), 32'(mq[0].excp));
    end
  endtask

  task automatic drive(bit v, logic [31:0] pc, bit e, bit rdy, bit fl, bit r);
    in_valid  = v;
    in_pc     = pc;
    in_inst   = $urandom;
    in_excp   = e;
    out_ready = rdy;
    flush     = fl;
    rst       = r;
  endtask

  // Advance the model by the queue's rules, then clock the DUT and compare.
  task automatic cycle(string tag);
    fetch_entry_t e;
    bit do_pop;
    bit do_push;
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0;
    end else if (flush) begin
      mq.delete();
    end else begin
      do_pop  = (mq.size() != 0) && out_ready;
      do_push = in_valid && ((mq.size() < DEPTH) || do_pop);
      if (in_valid && !do_push) m_ovf = 1'b1;
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        e.pc = in_pc; e.inst = in_inst; e.excp = in_excp;
        mq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 1);
    cycle("reset");
    cycle("reset");
    chk("rst.count", 32'(count), 0);
    chk("rst.out_valid", 32'(out_valid), 0);
    chk("rst.full", 32'(full), 0);
    chk("rst.almost_full", 32'(almost_full), 0);
    chk("rst.ovf", 32'(ovf), 0);

    // three pushes without consumption
    drive(1, 32'h1000, 0, 0, 0, 0); cycle("push3");
    chk("first.out_valid", 32'(out_valid), 1);
    chk("first.out_pc", out_pc, 32'h1000);
    drive(1, 32'h1004, 0, 0, 0, 0); cycle("push3");
    drive(1, 32'h1008, 0, 0, 0, 0); cycle("push3");
    chk("push3.count", 32'(count), 3);
    chk("push3.out_pc", out_pc, 32'h1000);

    // fill to full and overflow
    for (int i = 3; i < 8; i++) begin
      drive(1, 32'h1000 + 32'(4 * i), 0, 0, 0, 0); cycle("fill");
      if (i == 4) chk("fill5.almost_full", 32'(almost_full), 0);
      if (i == 5) chk("fill6.almost_full", 32'(almost_full), 1);
      if (i == 6) chk("fill7.full", 32'(full), 0);
    end
    chk("fill8.full", 32'(full), 1);
    chk("fill8.count", 32'(count), 8);
    drive(1, 32'h1020, 0, 0, 0, 0); cycle("ovf");
    chk("ovf.count", 32'(count), 8);
    chk("ovf.flag", 32'(ovf), 1);
    chk("ovf.out_pc", out_pc, 32'h1000);

    // full with simultaneous push and pop
    drive(1, 32'h2000, 0, 1, 0, 0); cycle("fullpp");
    chk("fullpp.count", 32'(count), 8);
    chk("fullpp.out_pc", out_pc, 32'h1004);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) chk("fullpp.last_pc", out_pc, 32'h2000);
      drive(0, 0, 0, 1, 0, 0); cycle("drain");
    end
    chk("drain.out_valid", 32'(out_valid), 0);

    // flush at count 5 with in_valid/out_ready asserted
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'h3000 + 32'(4 * i), 0, 0, 0, 0); cycle("pre_flush");
    end
    chk("pre_flush.count", 32'(count), 5);
    drive(1, 32'h3100, 0, 1, 1, 0); cycle("flush");
    chk("flush.count", 32'(count), 0);
    chk("flush.out_valid", 32'(out_valid), 0);
    chk("flush.ovf_kept", 32'(ovf), 1);
    drive(1, 32'h4000, 0, 0, 0, 0); cycle("post_flush");
    chk("post_flush.out_pc", out_pc, 32'h4000);
    chk("post_flush.count", 32'(count), 1);

    // steady push/pop across pointer wrap
    for (int i = 0; i < 20; i++) begin
      drive(1, 32'h5000 + 32'(4 * i), 0, 1, 0, 0); cycle("stream");
      chk("stream.count", 32'(count), 1);
      chk("stream.out_pc", out_pc, 32'h5000 + 32'(4 * i));
    end
    drive(0, 0, 0, 1, 0, 0); cycle("stream_drain");

    // exception flag rides with its entry
    drive(1, 32'h6000, 0, 0, 0, 0); cycle("excp");
    drive(1, 32'h6004, 1, 0, 0, 0); cycle("excp");
    drive(1, 32'h6008, 0, 0, 0, 0); cycle("excp");
    chk("excp.head0", 32'(out_excp), 0);
    drive(0, 0, 0, 1, 0, 0); cycle("excp_pop");
    chk("excp.head1", 32'(out_excp), 1);
    chk("excp.head1_pc", out_pc, 32'h6004);
    drive(0, 0, 0, 1, 0, 0); cycle("excp_pop");
    chk("excp.head2", 32'(out_excp), 0);

    // reset beats flush and push in the same cycle, and clears ovf
    drive(1, 32'h7000, 0, 1, 1, 1); cycle("rst_prio");
    chk("rst_prio.count", 32'(count), 0);
    chk("rst_prio.ovf", 32'(ovf), 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) == 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 99) < 3,
            $urandom_range(0, 199) == 0);
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 Parameter DEPTH, default 8, number of queue entries; power of two, >= 4.
REQ-002 Parameter AF_LEVEL, default 2, free-entry threshold for almost_full; 1 <= AF_LEVEL < DEPTH.
REQ-003 clk  in  1  clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset rst, synchronous, active-high.
REQ-005 flush  in  1  pipeline redirect; discards all queued and in-flight entries.
REQ-006 in_valid  in  1  fetch stage delivers one instruction this cycle (cache hit or refill done, not stalled).
REQ-007 in_pc  in  32  PC of delivered instruction.
REQ-008 in_inst  in  32  instruction word from the instruction cache.
REQ-009 in_excp  in  1  fetch exception flag (address error) carried with the entry.
REQ-010 almost_full  out  1  asserted when free entries <= AF_LEVEL; upstream PC stage stops issuing.
REQ-011 full  out  1  count == DEPTH.
REQ-012 out_valid  out  1  head entry present (count != 0).
REQ-013 out_pc / out_inst  out  32 / 32  head entry PC / instruction.
REQ-014 out_excp  out  1  head entry exception flag.
REQ-015 out_ready  in  1  decode consumes the head entry this cycle.
REQ-016 count  out  $clog2(DEPTH)+1  current occupancy.
REQ-017 ovf  out  1  sticky overflow error flag.

Function
REQ-018 Push occurs when in_valid && !flush && (!full || pop); the entry is written at tail and tail advances by 1.
REQ-019 Pop occurs when out_valid && out_ready && !flush; head advances by 1.
REQ-020 First-word fall-through: out_* SHALL be driven combinationally from the head slot; no data is taken from in_* in the same cycle.
REQ-021 Latency: an entry pushed in cycle N is visible on out_valid/out_* in cycle N+1.
REQ-022 Head/tail pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
REQ-023 count updates +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-024 Full with simultaneous pop and push: both occur; count stays DEPTH; order preserved.
REQ-025 Empty: out_valid = 0; out_ready is ignored; out_pc/out_inst/out_excp are don't-care.
REQ-026 in_valid while full without pop: entry is dropped, state is unchanged, and ovf is set to 1 on the next edge.
REQ-027 flush: on the next edge head = tail = 0 and count = 0; in_valid and out_ready in the flush cycle are ignored; ovf is unaffected.
REQ-028 almost_full and full are combinational from count; AF_LEVEL = 2 covers the two in-flight cache stages after the PC stage stops.
REQ-029 Entries leave in exact push order; the exception flag travels with its entry.

Reset
REQ-030 On rst: head = 0, tail = 0, count = 0, ovf = 0; out_valid = 0, full = 0, almost_full = 0.
REQ-031 Storage array contents are not reset.
REQ-032 rst overrides flush, push, and pop in the same cycle.

Structure
REQ-033 Package fetch_pkg holds typedef fetch_entry_t {pc[31:0], inst[31:0], excp} and the constant IQ_DEPTH = 8.
REQ-034 Storage is an inline fetch_entry_t register array (distributed, async read); no sub-module is required.

Verification
REQ-035 After rst, push 3 entries (PC 0x1000/0x1004/0x1008) with out_ready = 0 -> count = 3, out_pc = 0x1000 from the cycle after the first push.
REQ-036 Fill to 8 with out_ready = 0 -> almost_full from count = 6, full at 8; a further in_valid -> count stays 8 and ovf = 1.
REQ-037 Full, then in_valid = 1 and out_ready = 1 together -> count stays 8, head PC advances, and the new PC appears last after 8 pops.
REQ-038 Count 5, flush with in_valid and out_ready high -> next cycle count = 0, out_valid = 0; the following push is visible one cycle later.
REQ-039 Push/pop every cycle for 20 cycles -> wrap-around with output PC sequence identical to input; count constant at 1.
REQ-040 Push entry with in_excp = 1 between two normal entries -> out_excp = 1 only when that entry is at head.
